// File: rtl/dram_fifo_responder.sv
// dram_fifo_responder: in-order burst DRAM responder with a write-data FIFO over an on-chip memory
module dram_fifo_responder #(
  parameter int DDRAWidth = 28,
  parameter int DDRCWidth = 3,
  parameter int DDRDWidth = 64,
  parameter int DDRMWidth = 8,
  parameter int BurstLen = 8,
  parameter int MemAWidth = 12,
  parameter int ReadLatency = 4,
  parameter int WrFIFODepth = 16,
  parameter logic [DDRCWidth-1:0] CmdWrite = '0,
  parameter logic [DDRCWidth-1:0] CmdRead = DDRCWidth'(1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DDRAWidth-1:0] DRAMAddress,
  input  logic [DDRCWidth-1:0] DRAMCommand,
  input  logic                 DRAMCommandValid,
  output logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMReadData,
  output logic                 DRAMReadDataValid,
  input  logic [DDRDWidth-1:0] DRAMWriteData,
  input  logic [DDRMWidth-1:0] DRAMWriteMask,
  input  logic                 DRAMWriteDataValid,
  output logic                 DRAMWriteDataReady
);
  localparam int BW = $clog2(BurstLen);
  localparam int FW = $clog2(WrFIFODepth);
  localparam int LW = $clog2(ReadLatency);
  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, READ} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] wait_q, wait_d;
  logic [MemAWidth-BW-1:0] blk_q, blk_d;
  logic [FW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DDRMWidth+DDRDWidth-1:0] fifo_mem [WrFIFODepth];
  logic [DDRDWidth-1:0] mem [2**MemAWidth] = '{default: '0};
  logic [DDRMWidth+DDRDWidth-1:0] head;
  logic [DDRDWidth-1:0] keep;
  logic [MemAWidth-1:0] idx;
  logic full, empty, push, pop, cmd_fire, unused_addr;
  assign unused_addr = ^{DRAMAddress[DDRAWidth-1:MemAWidth], DRAMAddress[BW-1:0]};
  assign full = wr_ptr_q == {~rd_ptr_q[FW], rd_ptr_q[FW-1:0]};
  assign empty = wr_ptr_q == rd_ptr_q;
  assign DRAMCommandReady = state_q == IDLE && !Reset;
  assign DRAMWriteDataReady = !full && !Reset;
  assign DRAMReadDataValid = state_q == READ && !Reset;
  assign push = DRAMWriteDataValid && DRAMWriteDataReady;
  assign pop = state_q == WRITE && !empty && !Reset;
  assign cmd_fire = DRAMCommandValid && DRAMCommandReady;
  assign head = fifo_mem[rd_ptr_q[FW-1:0]];
  assign idx = {blk_q, beat_q};
  assign DRAMReadData = DRAMReadDataValid ? mem[idx] : '0;
  // Expand the per-byte mask (1 = keep old byte) to a bit mask
  always_comb begin
    keep = '0;
    for (int i = 0; i < DDRMWidth; i++) keep[i*8 +: 8] = {8{head[DDRDWidth+i]}};
  end
  // Next-state: command decode, burst beat counting and read-latency wait
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    wait_d = wait_q;
    blk_d = blk_q;
    wr_ptr_d = wr_ptr_q + (FW+1)'(push);
    rd_ptr_d = rd_ptr_q + (FW+1)'(pop);
    case (state_q)
      IDLE: if (cmd_fire) begin
        blk_d = DRAMAddress[MemAWidth-1:BW];
        beat_d = '0;
        wait_d = '0;
        state_d = DRAMCommand == CmdWrite ? WRITE : DRAMCommand == CmdRead ? RD_WAIT : IDLE;
      end
      WRITE: if (pop) begin
        beat_d = beat_q + 1'b1;
        state_d = &beat_q ? IDLE : WRITE;
      end
      RD_WAIT: begin
        wait_d = wait_q + 1'b1;
        state_d = wait_q == LW'(ReadLatency - 2) ? READ : RD_WAIT;
      end
      READ: begin
        beat_d = beat_q + 1'b1;
        state_d = &beat_q ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  // Control state registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      beat_q <= '0;
      wait_q <= '0;
      blk_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      wait_q <= wait_d;
      blk_q <= blk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Write-data FIFO storage; pointers alone define occupancy
  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr_q[FW-1:0]] <= {DRAMWriteMask, DRAMWriteData};
  end
  // Backing memory: merge popped beat under its byte mask, survives reset
  always_ff @(posedge Clock) begin
    if (pop) mem[idx] <= (mem[idx] & keep) | (head[DDRDWidth-1:0] & ~keep);
  end
endmodule

// File: tb/tb_dram_fifo_responder.sv
// tb_dram_fifo_responder: vector table plus directed sequences for dram_fifo_responder
module tb_dram_fifo_responder;
  localparam logic [2:0] CW = 3'b000, CR = 3'b001;
  logic clk = 0, rst = 1, cv = 0, wv = 0;
  logic [2:0] cmd = '0;
  logic [27:0] addr = '0;
  logic [63:0] wd = '0;
  logic [7:0] wm = '0;
  logic cr, rv, wr;
  logic [63:0] rd;
  logic [63:0] ex [8];
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic r, c;
    logic [2:0] cm;
    logic [27:0] a;
    logic w;
    logic [63:0] d;
    logic [7:0] m;
    logic e_cr, e_rv;
    logic [63:0] e_rd;
    logic e_wr;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  dram_fifo_responder dut (
    .Clock(clk), .Reset(rst), .DRAMAddress(addr), .DRAMCommand(cmd),
    .DRAMCommandValid(cv), .DRAMCommandReady(cr), .DRAMReadData(rd),
    .DRAMReadDataValid(rv), .DRAMWriteData(wd), .DRAMWriteMask(wm),
    .DRAMWriteDataValid(wv), .DRAMWriteDataReady(wr)
  );
  function automatic vec_t mk(input logic r, c, input logic [2:0] cm, input logic [27:0] a,
                              input logic w, input logic [63:0] d, input logic [7:0] m,
                              input logic e_cr, e_rv, input logic [63:0] e_rd, input logic e_wr);
    vec_t v;
    v.r = r; v.c = c; v.cm = cm; v.a = a; v.w = w; v.d = d; v.m = m;
    v.e_cr = e_cr; v.e_rv = e_rv; v.e_rd = e_rd; v.e_wr = e_wr;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] d, input logic [7:0] m);
    wv = 1; wd = d; wm = m;
    @(negedge clk);
    chk("push_wready", wr, 1);
    next();
    wv = 0;
  endtask
  task automatic do_write(input logic [27:0] a);
    cv = 1; cmd = CW; addr = a;
    @(negedge clk);
    chk("wr_cmd_ready", cr, 1);
    next();
    cv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("wr_busy_ready", cr, 0);
      next();
    end
    @(negedge clk);
    chk("wr_done_ready", cr, 1);
    next();
  endtask
  task automatic do_read(input logic [27:0] a);
    cv = 1; cmd = CR; addr = a;
    @(negedge clk);
    chk("rd_cmd_ready", cr, 1);
    next();
    cv = 0;
    for (int c = 1; c <= 12; c++) begin
      int j;
      logic act;
      act = c >= 4 && c < 12;
      j = act ? c - 4 : 0;
      @(negedge clk);
      chk("rd_valid", rv, act);
      chk("rd_data", rd, act ? ex[j] : 64'h0);
      chk("rd_cready", cr, c == 12);
      next();
    end
  endtask
  initial begin
    tbl.push_back(mk(1, 1, CW, 28'h40, 1, 64'h5, 8'h0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, CR, 28'h40, 1, 64'h6, 8'h0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, CW, 0, 1, 64'h11 * (k + 1), 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, CW, 28'h40, 0, 0, 0, 1, 0, 0, 1));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, CW, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, CR, 28'h40, 0, 0, 0, 1, 0, 0, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, CW, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, CW, 0, 0, 0, 0, 0, 1, 64'h11 * (k + 1), 1));
    tbl.push_back(mk(0, 0, CW, 0, 0, 0, 0, 1, 0, 0, 1));
    next();
    foreach (tbl[i]) begin
      rst = tbl[i].r; cv = tbl[i].c; cmd = tbl[i].cm; addr = tbl[i].a;
      wv = tbl[i].w; wd = tbl[i].d; wm = tbl[i].m;
      @(negedge clk);
      chk($sformatf("vec%0d_cready", i), cr, tbl[i].e_cr);
      chk($sformatf("vec%0d_rvalid", i), rv, tbl[i].e_rv);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].e_rd);
      chk($sformatf("vec%0d_wready", i), wr, tbl[i].e_wr);
      next();
    end
    rst = 0; cv = 0; wv = 0; wd = '0; wm = '0;
    next();
    cv = 1; cmd = CW; addr = 28'h0;
    @(negedge clk);
    chk("dac_cmd_ready", cr, 1);
    next();
    cv = 0;
    repeat (3) begin
      @(negedge clk);
      chk("dac_stall_ready", cr, 0);
      next();
    end
    for (int k = 0; k < 8; k++) begin
      ex[k] = 64'hCAFE_0000_0000_0000 | 64'(k);
      wv = 1; wd = ex[k]; wm = 0;
      @(negedge clk);
      chk("dac_busy_ready", cr, 0);
      chk("dac_wready", wr, 1);
      next();
    end
    wv = 0;
    @(negedge clk);
    chk("dac_last_ready", cr, 0);
    next();
    @(negedge clk);
    chk("dac_done_ready", cr, 1);
    next();
    do_read(28'h0);
    do_read(28'h1003);
    for (int k = 0; k < 8; k++) push(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    do_write(28'h80);
    for (int k = 0; k < 8; k++) begin
      push(64'h0, k[0] ? 8'hF0 : 8'h0F);
      ex[k] = k[0] ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF;
    end
    do_write(28'h85);
    do_read(28'h80);
    for (int k = 0; k < 16; k++) push(64'h100 + 64'(k), 8'h00);
    wv = 1; wd = 64'hDEAD; wm = 0;
    @(negedge clk);
    chk("full_wready", wr, 0);
    next();
    wv = 0;
    do_write(28'h200);
    @(negedge clk);
    chk("refill_wready", wr, 1);
    next();
    do_write(28'h208);
    for (int k = 0; k < 8; k++) ex[k] = 64'h100 + 64'(k);
    do_read(28'h200);
    for (int k = 0; k < 8; k++) ex[k] = 64'h108 + 64'(k);
    do_read(28'h208);
    cv = 1; cmd = CR; addr = 28'h40;
    next();
    cv = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("rst_pre_valid", rv, c >= 4);
      next();
    end
    rst = 1;
    @(negedge clk);
    chk("rst_valid", rv, 0);
    chk("rst_data", rd, 0);
    chk("rst_cready", cr, 0);
    chk("rst_wready", wr, 0);
    next();
    rst = 0;
    @(negedge clk);
    chk("post_rst_cready", cr, 1);
    chk("post_rst_valid", rv, 0);
    next();
    @(negedge clk);
    chk("post_rst_valid2", rv, 0);
    next();
    for (int k = 0; k < 8; k++) ex[k] = 64'h11 * (k + 1);
    do_read(28'h47);
    for (int k = 0; k < 3; k++) push(64'hBAD0 + 64'(k), 8'h00);
    rst = 1;
    next();
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      ex[k] = 64'h700 + 64'(k);
      push(ex[k], 8'h00);
    end
    do_write(28'h300);
    do_read(28'h300);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
